// File: rtl/pipe_mips32_fwd.sv
// Single-clock 5-stage MIPS32 core: EX forwarding, load-use interlock, branch flush,
// start/halt control and a bench load/debug port onto the unified memory and register file.
module pipe_mips32_fwd #(
   parameter int XLEN       = 32,
   parameter int MEM_DEPTH  = 1024,
   parameter int REG_COUNT  = 32,
   parameter int FORWARD_EN = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         ld_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
   input  logic [XLEN-1:0]              ld_data,
   output logic [XLEN-1:0]              mem_rdata,
   input  logic [4:0]                   dbg_raddr,
   output logic [XLEN-1:0]              dbg_rdata,
   output logic                         halted,
   output logic                         illegal,
   output logic [31:0]                  retired
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam int RW = $clog2(REG_COUNT);

   localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_AND   = 6'b000010,
                          OP_OR   = 6'b000011, OP_SLT  = 6'b000100, OP_MUL   = 6'b000101,
                          OP_LW   = 6'b001000, OP_SW   = 6'b001001, OP_ADDI  = 6'b001010,
                          OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
                          OP_BEQZ = 6'b001110, OP_HLT  = 6'b111111;

   typedef enum logic [2:0] {T_RR, T_RM, T_LW, T_SW, T_BR, T_HLT} itype_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

   logic [XLEN-1:0] mem  [MEM_DEPTH];
   logic [XLEN-1:0] regs [REG_COUNT];

   state_t          state;
   logic [AW-1:0]   pc;

   logic            if_id_v;
   logic [31:0]     if_id_ir;
   logic [AW-1:0]   if_id_npc;

   logic            id_ex_v, id_ex_wr, id_ex_ill;
   itype_t          id_ex_type;
   logic [5:0]      id_ex_op;
   logic [XLEN-1:0] id_ex_a, id_ex_b, id_ex_imm;
   logic [AW-1:0]   id_ex_npc;
   logic [RW-1:0]   id_ex_rs, id_ex_rt, id_ex_dest;

   logic            ex_mem_v, ex_mem_wr, ex_mem_ill;
   itype_t          ex_mem_type;
   logic [XLEN-1:0] ex_mem_alu, ex_mem_b;
   logic [RW-1:0]   ex_mem_dest;

   logic            mem_wb_v, mem_wb_wr, mem_wb_ill;
   itype_t          mem_wb_type;
   logic [XLEN-1:0] mem_wb_alu, mem_wb_lmd;
   logic [RW-1:0]   mem_wb_dest;

   // ID decode
   logic [5:0]      d_op;
   logic [RW-1:0]   d_rs, d_rt, d_rd, d_dest;
   logic [XLEN-1:0] d_imm, d_a, d_b;
   itype_t          d_type;
   logic            d_ill, d_use_rs, d_use_rt, d_wr;

   logic            wb_we;
   logic [XLEN-1:0] wb_val;
   logic            hazard, stall, flush, halt_in_id, taken;
   logic [XLEN-1:0] a_ex, b_ex, alu;
   logic [AW-1:0]   target;

   assign d_op   = if_id_ir[31:26];
   assign d_rs   = if_id_ir[21 +: RW];
   assign d_rt   = if_id_ir[16 +: RW];
   assign d_rd   = if_id_ir[11 +: RW];
   assign d_imm  = XLEN'(signed'(if_id_ir[15:0]));
   assign wb_we  = mem_wb_v && mem_wb_wr;
   assign wb_val = (mem_wb_type == T_LW) ? mem_wb_lmd : mem_wb_alu;

   always_comb begin
      d_type = T_HLT; d_ill = 1'b0; d_use_rs = 1'b0; d_use_rt = 1'b0; d_wr = 1'b0; d_dest = d_rt;
      case (d_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
            d_type = T_RR; d_use_rs = 1'b1; d_use_rt = 1'b1; d_wr = 1'b1; d_dest = d_rd;
         end
         OP_ADDI, OP_SUBI, OP_SLTI: begin d_type = T_RM; d_use_rs = 1'b1; d_wr = 1'b1; end
         OP_LW:             begin d_type = T_LW; d_use_rs = 1'b1; d_wr = 1'b1; end
         OP_SW:             begin d_type = T_SW; d_use_rs = 1'b1; d_use_rt = 1'b1; end
         OP_BEQZ, OP_BNEQZ: begin d_type = T_BR; d_use_rs = 1'b1; end
         OP_HLT:            d_type = T_HLT;
         default:           d_ill = 1'b1;
      endcase
      // Writes to register 0 are dropped, so such producers never forward or interlock.
      if (d_dest == '0) d_wr = 1'b0;
   end

   always_comb begin
      d_a = regs[d_rs];
      d_b = regs[d_rt];
      if (wb_we && mem_wb_dest == d_rs) d_a = wb_val;
      if (wb_we && mem_wb_dest == d_rt) d_b = wb_val;
      if (d_rs == '0) d_a = '0;
      if (d_rt == '0) d_b = '0;
   end

   always_comb begin
      hazard = 1'b0;
      if (FORWARD_EN != 0) begin
         hazard = id_ex_v && id_ex_type == T_LW && id_ex_wr &&
                  ((d_use_rs && id_ex_dest == d_rs) || (d_use_rt && id_ex_dest == d_rt));
      end else begin
         hazard = (d_use_rs && ((id_ex_v && id_ex_wr && id_ex_dest == d_rs) ||
                                (ex_mem_v && ex_mem_wr && ex_mem_dest == d_rs))) ||
                  (d_use_rt && ((id_ex_v && id_ex_wr && id_ex_dest == d_rt) ||
                                (ex_mem_v && ex_mem_wr && ex_mem_dest == d_rt)));
      end
   end

   always_comb begin
      a_ex = id_ex_a;
      b_ex = id_ex_b;
      if (FORWARD_EN != 0) begin
         if (ex_mem_v && ex_mem_wr && ex_mem_dest == id_ex_rs) a_ex = ex_mem_alu;
         else if (wb_we && mem_wb_dest == id_ex_rs)            a_ex = wb_val;
         if (ex_mem_v && ex_mem_wr && ex_mem_dest == id_ex_rt) b_ex = ex_mem_alu;
         else if (wb_we && mem_wb_dest == id_ex_rt)            b_ex = wb_val;
      end
   end

   always_comb begin
      alu = '0;
      case (id_ex_op)
         OP_ADD:                alu = a_ex + b_ex;
         OP_SUB:                alu = a_ex - b_ex;
         OP_AND:                alu = a_ex & b_ex;
         OP_OR:                 alu = a_ex | b_ex;
         OP_SLT:                alu = {{(XLEN-1){1'b0}}, a_ex < b_ex};
         OP_MUL:                alu = a_ex * b_ex;
         OP_ADDI, OP_LW, OP_SW: alu = a_ex + id_ex_imm;
         OP_SUBI:               alu = a_ex - id_ex_imm;
         OP_SLTI:               alu = {{(XLEN-1){1'b0}}, a_ex < id_ex_imm};
         default:               alu = '0;
      endcase
   end

   assign taken      = (id_ex_op == OP_BEQZ) ? (a_ex == '0) : (a_ex != '0);
   assign target     = id_ex_npc + id_ex_imm[AW-1:0];
   assign flush      = id_ex_v && id_ex_type == T_BR && taken;
   // The stalled consumer is younger than a resolving branch, so the flush takes precedence.
   assign stall      = if_id_v && hazard && !flush;
   assign halt_in_id = if_id_v && d_type == T_HLT && !flush;

   assign mem_rdata = mem[ld_addr];
   assign dbg_rdata = (dbg_raddr[RW-1:0] == '0) ? '0 : regs[dbg_raddr[RW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (ex_mem_v && ex_mem_type == T_SW) mem[ex_mem_alu[AW-1:0]] <= ex_mem_b;
         else if (ld_we && (state == S_IDLE || state == S_HALTED)) mem[ld_addr] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wb_we) regs[mem_wb_dest] <= wb_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE; pc <= '0; halted <= 1'b0; illegal <= 1'b0; retired <= '0;
         if_id_v <= 1'b0; id_ex_v <= 1'b0; ex_mem_v <= 1'b0; mem_wb_v <= 1'b0;
      end else begin
         if (flush) begin
            pc <= target; if_id_v <= 1'b0;
         end else if (!stall) begin
            if (state == S_RUN && !halt_in_id) begin
               if_id_v <= 1'b1; if_id_ir <= mem[pc]; if_id_npc <= pc + AW'(1); pc <= pc + AW'(1);
            end else begin
               if_id_v <= 1'b0;
            end
         end

         id_ex_v    <= if_id_v && !flush && !stall;
         id_ex_type <= d_type;  id_ex_op   <= d_op;   id_ex_ill <= d_ill;
         id_ex_a    <= d_a;     id_ex_b    <= d_b;    id_ex_imm <= d_imm;
         id_ex_npc  <= if_id_npc;
         id_ex_rs   <= d_rs;    id_ex_rt   <= d_rt;
         id_ex_dest <= d_dest;  id_ex_wr   <= d_wr;

         ex_mem_v    <= id_ex_v;    ex_mem_type <= id_ex_type; ex_mem_alu <= alu;
         ex_mem_b    <= b_ex;       ex_mem_dest <= id_ex_dest; ex_mem_wr  <= id_ex_wr;
         ex_mem_ill  <= id_ex_ill;

         mem_wb_v    <= ex_mem_v;    mem_wb_type <= ex_mem_type; mem_wb_alu <= ex_mem_alu;
         mem_wb_lmd  <= mem[ex_mem_alu[AW-1:0]];
         mem_wb_dest <= ex_mem_dest; mem_wb_wr   <= ex_mem_wr;   mem_wb_ill <= ex_mem_ill;

         if (mem_wb_v) retired <= retired + 32'd1;

         case (state)
            S_IDLE, S_HALTED: if (start) begin
               state <= S_RUN; pc <= '0; retired <= '0; halted <= 1'b0; illegal <= 1'b0;
            end
            S_RUN:   if (halt_in_id) state <= S_DRAIN;
            S_DRAIN: if (mem_wb_v && mem_wb_type == T_HLT) begin
               state <= S_HALTED; halted <= 1'b1; illegal <= mem_wb_ill;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// Directed bench for pipe_mips32_fwd: runs each program on a forwarding build and an
// interlock-only build side by side, checking results, retire counts and cycle counts.
module tb_pipe_mips32_fwd;
   localparam logic [5:0] ADD = 6'b000000, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001,
                          ADDI = 6'b001010, SUBI = 6'b001011, BNEQZ = 6'b001101,
                          BEQZ = 6'b001110;
   localparam logic [31:0] HLT_W = 32'hFC00_0000;

   logic        clk, rst, start, ld_we;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;
   logic [4:0]  dbg_raddr;
   logic [31:0] mem_rdata_f, dbg_rdata_f, retired_f, mem_rdata_i, dbg_rdata_i, retired_i;
   logic        halted_f, illegal_f, halted_i, illegal_i;

   int checks = 0;
   int errors = 0;
   int cyc_f, cyc_i;
   logic [31:0] prog[$];
   logic [31:0] exp_q[$];
   int          idx_q[$];

   pipe_mips32_fwd #(.FORWARD_EN(1)) u_fwd (
      .clk(clk), .rst(rst), .start(start), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .mem_rdata(mem_rdata_f), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata_f),
      .halted(halted_f), .illegal(illegal_f), .retired(retired_f));

   pipe_mips32_fwd #(.FORWARD_EN(0)) u_ilk (
      .clk(clk), .rst(rst), .start(start), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .mem_rdata(mem_rdata_i), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata_i),
      .halted(halted_i), .illegal(illegal_i), .retired(retired_i));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rr(input logic [5:0] op, input int rs, input int rt, input int rd);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] ri(input logic [5:0] op, input int rs, input int rt, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic poke_mem(input int addr, input logic [31:0] data);
      ld_we = 1'b1; ld_addr = 10'(addr); ld_data = data;
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   task automatic load_prog();
      for (int i = 0; i < prog.size(); i++) poke_mem(i, prog[i]);
   endtask

   task automatic run_prog(input bit poke, output int cf, output int ci);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cf = -1; ci = -1;
      for (int c = 1; c <= 400 && (cf < 0 || ci < 0); c++) begin
         if (poke && c == 5) begin
            start = 1'b1; ld_we = 1'b1; ld_addr = 10'd300; ld_data = 32'h55;
         end
         @(negedge clk);
         start = 1'b0; ld_we = 1'b0;
         if (halted_f && cf < 0) cf = c;
         if (halted_i && ci < 0) ci = c;
      end
   endtask

   task automatic chk_reg(input int idx, input logic [31:0] val);
      dbg_raddr = 5'(idx);
      #1;
      chk($sformatf("r%0d_fwd", idx), dbg_rdata_f, val);
      chk($sformatf("r%0d_ilk", idx), dbg_rdata_i, val);
   endtask

   task automatic chk_mem(input int addr, input logic [31:0] val);
      ld_addr = 10'(addr);
      #1;
      chk($sformatf("mem%0d_fwd", addr), mem_rdata_f, val);
      chk($sformatf("mem%0d_ilk", addr), mem_rdata_i, val);
   endtask

   task automatic chk_status(input string tag, input logic h, input logic il, input logic [31:0] r);
      chk({tag, "_halted_fwd"},  32'(halted_f),  32'(h));
      chk({tag, "_halted_ilk"},  32'(halted_i),  32'(h));
      chk({tag, "_illegal_fwd"}, 32'(illegal_f), 32'(il));
      chk({tag, "_illegal_ilk"}, 32'(illegal_i), 32'(il));
      chk({tag, "_retired_fwd"}, retired_f, r);
      chk({tag, "_retired_ilk"}, retired_i, r);
   endtask

   // scoreboard: expected register values queued per program, drained after it halts
   task automatic expect_reg(input int idx, input logic [31:0] val);
      idx_q.push_back(idx);
      exp_q.push_back(val);
   endtask

   task automatic drain_scoreboard();
      while (exp_q.size() > 0) chk_reg(idx_q.pop_front(), exp_q.pop_front());
   endtask

   task automatic load_factorial();
      prog = {ri(ADDI, 0, 10, 200), ri(ADDI, 0, 2, 1), ri(LW, 10, 3, 0), rr(MUL, 2, 3, 2),
              ri(SUBI, 3, 3, 1), ri(BNEQZ, 3, 0, -3), ri(SW, 10, 2, -2), HLT_W};
      load_prog();
      poke_mem(200, 32'd5);
      poke_mem(198, 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; dbg_raddr = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_status("reset", 1'b0, 1'b0, 32'd0);

      // dependent ALU chain, fully forwarded
      prog = {ri(ADDI, 0, 1, 10), ri(ADDI, 0, 2, 20), rr(ADD, 1, 2, 3), HLT_W};
      load_prog();
      run_prog(1'b0, cyc_f, cyc_i);
      chk("alu_cycles_fwd", cyc_f, 32'd8);
      chk("alu_cycles_ilk", cyc_i, 32'd10);
      chk_status("alu", 1'b1, 1'b0, 32'd4);
      expect_reg(1, 32'd10); expect_reg(2, 32'd20); expect_reg(3, 32'd30);
      drain_scoreboard();

      // load-use: exactly one bubble with forwarding
      poke_mem(100, 32'd7);
      prog = {ri(ADDI, 0, 1, 100), ri(LW, 1, 2, 0), rr(ADD, 2, 2, 3), HLT_W};
      load_prog();
      run_prog(1'b0, cyc_f, cyc_i);
      chk("lu_cycles_fwd", cyc_f, 32'd9);
      chk("lu_cycles_ilk", cyc_i, 32'd12);
      chk_status("lu", 1'b1, 1'b0, 32'd4);
      expect_reg(2, 32'd7); expect_reg(3, 32'd14);
      drain_scoreboard();

      // not-taken BNEQZ costs nothing; taken BEQZ squashes two ADDIs
      prog = {ri(ADDI, 0, 5, 9), ri(BNEQZ, 0, 0, 5), ri(BEQZ, 0, 0, 2),
              ri(ADDI, 0, 5, 1), ri(ADDI, 0, 5, 1), HLT_W};
      load_prog();
      run_prog(1'b0, cyc_f, cyc_i);
      chk("br_cycles_fwd", cyc_f, 32'd10);
      chk("br_cycles_ilk", cyc_i, 32'd10);
      chk_status("br", 1'b1, 1'b0, 32'd4);
      expect_reg(5, 32'd9);
      drain_scoreboard();

      // undefined opcode halts; younger ADDI never writes
      prog = {ri(ADDI, 0, 6, 3), 32'h5400_0000, ri(ADDI, 0, 6, 77), HLT_W};
      load_prog();
      run_prog(1'b0, cyc_f, cyc_i);
      chk("ill_cycles_fwd", cyc_f, 32'd6);
      chk("ill_cycles_ilk", cyc_i, 32'd6);
      chk_status("ill", 1'b1, 1'b1, 32'd2);
      expect_reg(6, 32'd3);
      drain_scoreboard();

      // factorial(5); start and ld_we poked mid-run must be ignored
      load_factorial();
      poke_mem(300, 32'd0);
      run_prog(1'b1, cyc_f, cyc_i);
      chk("fact_cycles_fwd", cyc_f, 32'd33);
      chk("fact_ilk_slower", 32'(cyc_i > cyc_f), 32'd1);
      chk_status("fact", 1'b1, 1'b0, 32'd20);
      chk_mem(198, 32'd120);
      chk_mem(300, 32'd0);
      expect_reg(2, 32'd120); expect_reg(3, 32'd0);
      drain_scoreboard();

      // reset in the middle of the loop, then reload and rerun
      load_factorial();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_status("midrst", 1'b0, 1'b0, 32'd0);
      chk_mem(198, 32'd0);
      load_factorial();
      run_prog(1'b0, cyc_f, cyc_i);
      chk("rerun_cycles_fwd", cyc_f, 32'd33);
      chk("rerun_ilk_slower", 32'(cyc_i > cyc_f), 32'd1);
      chk_status("rerun", 1'b1, 1'b0, 32'd20);
      chk_mem(198, 32'd120);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
